// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that owns the UART transmit byte bus.
// One byte is driven until the UART takes it, then the bus rests at 00.
module uart_tx_scheduler #(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               uart_tx_ready,
  output logic [7:0]         uart_tx_bits,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               tx_done,
  output logic               err_illegal,
  output logic               err_timeout
);

  localparam int PW = (N_REQ > 2) ? 2 : 1;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);
  localparam logic [PW:0] N_WIDE = (PW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    nxt_ptr;
  logic [PW:0]      cand;
  logic             sel_hit;
  logic [7:0]       sel_byte;
  logic [N_REQ-1:0] sel_oh;
  logic [15:0]      cnt;

  // scan from ptr upward with wrap; first valid requester wins
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= N_WIDE)
        cand = cand - N_WIDE;
      if (!sel_hit && req_valid[cand[PW-1:0]]) begin
        sel_hit = 1'b1;
        sel_idx = cand[PW-1:0];
      end
    end
  end

  assign sel_byte = req_data[{sel_idx, 3'b000} +: 8];
  assign sel_oh   = N_REQ'(1) << sel_idx;
  assign nxt_ptr  = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;

  assign req_ready = (state == IDLE && sel_hit) ? sel_oh : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      uart_tx_bits <= 8'h00;
      grant        <= '0;
      tx_done      <= 1'b0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_hit) begin
            ptr <= nxt_ptr;
            cnt <= '0;
            if (sel_byte[1:0] != 2'b00) begin
              uart_tx_bits <= sel_byte;
              grant        <= sel_oh;
              state        <= SEND;
            end else begin
              err_illegal <= 1'b1;
              state       <= GAP;
            end
          end
        end
        SEND: begin
          // success wins over a timeout landing in the same cycle
          if (uart_tx_ready) begin
            uart_tx_bits <= 8'h00;
            grant        <= '0;
            tx_done      <= 1'b1;
            cnt          <= '0;
            state        <= GAP;
          end else if (cnt == TO_LAST) begin
            uart_tx_bits <= 8'h00;
            grant        <= '0;
            err_timeout  <= 1'b1;
            cnt          <= '0;
            state        <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios plus a randomized run
// checked against a transaction-timeline model of the scheduler.
module tb_uart_tx_scheduler;

  localparam int NR = 3;
  localparam int G  = 16;
  localparam int T  = 40;

  logic            clock;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            uart_tx_ready;
  logic [7:0]      uart_tx_bits;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            tx_done;
  logic            err_illegal;
  logic            err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(
    .N_REQ(NR),
    .GAP_CYCLES(G),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_tx_ready(uart_tx_ready),
    .uart_tx_bits(uart_tx_bits),
    .grant(grant),
    .busy(busy),
    .tx_done(tx_done),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    req_valid = '0;
    uart_tx_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got=%b exp=0", nm, busy);
    end
  endtask

  function automatic int pick(input int p, input logic [NR-1:0] vv);
    for (int k = 0; k < NR; k++)
      if (vv[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    uart_tx_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (uart_tx_bits !== 8'h00) begin errors++; $display("FAIL reset_bits got=%h exp=00", uart_tx_bits); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_ill got=%b exp=0", err_illegal); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_to got=%b exp=0", err_timeout); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_send();
    int g, nd;
    tick();
    req_valid = 3'b001;
    req_data = 24'h000015;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (uart_tx_bits !== 8'h15) begin errors++; $display("FAIL single_bits got=%h exp=15", uart_tx_bits); end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant got=%b exp=001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_ready_send got=%b exp=000", req_ready); end
    repeat (18) tick();
    tick();
    uart_tx_ready = 1'b1;
    #1;
    checks++; if (uart_tx_bits !== 8'h15) begin errors++; $display("FAIL single_hold got=%h exp=15", uart_tx_bits); end
    tick();
    uart_tx_ready = 1'b0;
    #1;
    checks++; if (uart_tx_bits !== 8'h00) begin errors++; $display("FAIL single_clear got=%h exp=00", uart_tx_bits); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", tx_done); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_grant_clr got=%b exp=000", grant); end
    g = 1;
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      #1;
      if (!busy) break;
      g++;
      nd += int'(tx_done);
    end
    checks++; if (g != G) begin errors++; $display("FAIL single_gap got=%0d exp=%0d", g, G); end
    checks++; if (nd != 0) begin errors++; $display("FAIL single_done_width got=%0d exp=0", nd); end
  endtask

  task automatic test_round_robin();
    int ord[$];
    logic [7:0] seq[$];
    logic [7:0] last;
    int nz, dn, got;
    logic [7:0] exp_seq [8];
    int exp_ord [4];
    exp_seq = '{8'h21, 8'h00, 8'h42, 8'h00, 8'h21, 8'h00, 8'h42, 8'h00};
    exp_ord = '{0, 1, 0, 1};
    pulse_reset();
    last = 8'h00;
    nz = 0;
    dn = 0;
    for (int t = 0; t < 400 && dn < 4; t++) begin
      tick();
      req_valid = 3'b011;
      req_data = 24'h004221;
      uart_tx_ready = (nz == 20);
      #1;
      if (req_ready == 3'b001) ord.push_back(0);
      else if (req_ready == 3'b010) ord.push_back(1);
      else if (req_ready != 3'b000) ord.push_back(9);
      if (uart_tx_bits != last) begin
        seq.push_back(uart_tx_bits);
        last = uart_tx_bits;
      end
      nz = (uart_tx_bits != 8'h00) ? nz + 1 : 0;
      dn += int'(tx_done);
    end
    tick();
    req_valid = '0;
    uart_tx_ready = 1'b0;
    checks++; if (dn != 4) begin errors++; $display("FAIL rr_dones got=%0d exp=4", dn); end
    checks++; if (ord.size() != 4) begin errors++; $display("FAIL rr_nacc got=%0d exp=4", ord.size()); end
    checks++; if (seq.size() != 8) begin errors++; $display("FAIL rr_nseq got=%0d exp=8", seq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < ord.size()) ? ord[i] : -1;
      checks++; if (got != exp_ord[i]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, got, exp_ord[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < seq.size()) ? int'(seq[i]) : -1;
      checks++; if (got != int'(exp_seq[i])) begin errors++; $display("FAIL rr_seq[%0d] got=%0h exp=%0h", i, got, exp_seq[i]); end
    end
    drain("rr_drain");
  endtask

  task automatic test_illegal();
    int k, ni, nd;
    tick();
    req_valid = 3'b010;
    req_data = 24'h00FC55;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL ill_ready got=%b exp=010", req_ready); end
    tick();
    req_valid = 3'b001;
    #1;
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%b exp=1", err_illegal); end
    checks++; if (uart_tx_bits !== 8'h00) begin errors++; $display("FAIL ill_bits got=%h exp=00", uart_tx_bits); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ill_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL ill_gap_ready got=%b exp=000", req_ready); end
    k = 1;
    ni = 0;
    nd = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      #1;
      k++;
      if (req_ready != 3'b000) break;
      ni += int'(err_illegal);
      nd += int'(tx_done);
    end
    checks++; if (k != G + 1) begin errors++; $display("FAIL ill_next_at got=%0d exp=%0d", k, G + 1); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL ill_next_ready got=%b exp=001", req_ready); end
    checks++; if (ni != 0) begin errors++; $display("FAIL ill_width got=%0d exp=0", ni); end
    checks++; if (nd != 0) begin errors++; $display("FAIL ill_no_done got=%0d exp=0", nd); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (uart_tx_bits !== 8'h55) begin errors++; $display("FAIL ill_next_bits got=%h exp=55", uart_tx_bits); end
    repeat (4) tick();
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    drain("ill_drain");
  endtask

  task automatic test_timeout();
    int n, m, nd, nt;
    logic [7:0] bt;
    tick();
    req_valid = 3'b001;
    req_data = 24'h000003;
    uart_tx_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL to_ready got=%b exp=001", req_ready); end
    n = 0;
    nd = 0;
    bt = 8'h00;
    for (int i = 0; i < T + 20; i++) begin
      tick();
      req_valid = '0;
      #1;
      n++;
      if (n == T) bt = uart_tx_bits;
      if (err_timeout) break;
      nd += int'(tx_done);
    end
    checks++; if (n != T + 1) begin errors++; $display("FAIL to_at got=%0d exp=%0d", n, T + 1); end
    checks++; if (bt !== 8'h03) begin errors++; $display("FAIL to_last_bits got=%h exp=03", bt); end
    checks++; if (uart_tx_bits !== 8'h00) begin errors++; $display("FAIL to_bits got=%h exp=00", uart_tx_bits); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL to_grant got=%b exp=000", grant); end
    checks++; if (nd != 0 || tx_done !== 1'b0) begin errors++; $display("FAIL to_no_done got=%0d exp=0", nd); end
    m = n;
    nt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      #1;
      m++;
      if (!busy) break;
      nt += int'(err_timeout);
    end
    checks++; if (m != T + 1 + G) begin errors++; $display("FAIL to_idle_at got=%0d exp=%0d", m, T + 1 + G); end
    checks++; if (nt != 0) begin errors++; $display("FAIL to_width got=%0d exp=0", nt); end
  endtask

  task automatic test_race();
    logic [7:0] bt;
    bt = 8'h00;
    tick();
    req_valid = 3'b001;
    req_data = 24'h000007;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL race_ready got=%b exp=001", req_ready); end
    for (int n = 1; n <= T; n++) begin
      tick();
      req_valid = '0;
      uart_tx_ready = (n == T);
      #1;
      if (n == T) bt = uart_tx_bits;
    end
    tick();
    uart_tx_ready = 1'b0;
    #1;
    checks++; if (bt !== 8'h07) begin errors++; $display("FAIL race_bits got=%h exp=07", bt); end
    checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL race_done got=%b exp=1", tx_done); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL race_to got=%b exp=0", err_timeout); end
    tick();
    #1;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL race_to_late got=%b exp=0", err_timeout); end
    drain("race_drain");
  endtask

  task automatic test_reset_mid_send();
    tick();
    req_valid = 3'b001;
    req_data = 24'h00002D;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rms_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    repeat (2) tick();
    #1;
    checks++; if (uart_tx_bits !== 8'h2D) begin errors++; $display("FAIL rms_bits got=%h exp=2d", uart_tx_bits); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 3'b011;
    req_data = 24'h003311;
    #1;
    checks++; if (uart_tx_bits !== 8'h00) begin errors++; $display("FAIL rms_clr_bits got=%h exp=00", uart_tx_bits); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rms_grant got=%b exp=000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy got=%b exp=0", busy); end
    checks++; if ({tx_done, err_illegal, err_timeout} !== 3'b000) begin errors++; $display("FAIL rms_pulses got=%b exp=000", {tx_done, err_illegal, err_timeout}); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rms_ptr got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (uart_tx_bits !== 8'h11) begin errors++; $display("FAIL rms_next_bits got=%h exp=11", uart_tx_bits); end
    repeat (3) tick();
    tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    drain("rms_drain");
  endtask

  task automatic test_random();
    logic [NR-1:0] v;
    logic [7:0] dat [NR];
    int ptr, idle_at, acc, s, d, gi, pk;
    logic legal, rdy, insend, busy_e, done_e, to_e, ill_e;
    logic [7:0] byt, bits_e;
    logic [NR-1:0] gr_e, rr_e;
    v = '0;
    for (int i = 0; i < NR; i++) dat[i] = 8'h00;
    ptr = 0;
    idle_at = 0;
    acc = -100;
    s = 0;
    d = 0;
    gi = 0;
    legal = 1'b0;
    byt = 8'h00;
    pulse_reset();
    for (int t = 0; t < 2500; t++) begin
      tick();
      for (int i = 0; i < NR; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          dat[i] = 8'($urandom);
        end
      rdy = (legal && t == acc + d) ||
            ($urandom_range(0, 19) == 0 && !(t > acc && t <= acc + s));
      req_valid = v;
      for (int i = 0; i < NR; i++) req_data[8*i +: 8] = dat[i];
      uart_tx_ready = rdy;
      #1;
      insend = legal && t > acc && t <= acc + s;
      busy_e = (t < idle_at);
      bits_e = insend ? byt : 8'h00;
      gr_e = insend ? NR'(1) << gi : '0;
      done_e = legal && d <= T && t == acc + s + 1;
      to_e = legal && d > T && t == acc + s + 1;
      ill_e = !legal && t == acc + 1;
      pk = pick(ptr, v);
      rr_e = (busy_e || pk < 0) ? '0 : NR'(1) << pk;
      checks++; if (uart_tx_bits !== bits_e) begin errors++; $display("FAIL rnd_bits t=%0d got=%h exp=%h", t, uart_tx_bits, bits_e); end
      checks++; if (grant !== gr_e) begin errors++; $display("FAIL rnd_grant t=%0d got=%b exp=%b", t, grant, gr_e); end
      checks++; if (busy !== busy_e) begin errors++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, busy, busy_e); end
      checks++; if (tx_done !== done_e) begin errors++; $display("FAIL rnd_done t=%0d got=%b exp=%b", t, tx_done, done_e); end
      checks++; if (err_timeout !== to_e) begin errors++; $display("FAIL rnd_to t=%0d got=%b exp=%b", t, err_timeout, to_e); end
      checks++; if (err_illegal !== ill_e) begin errors++; $display("FAIL rnd_ill t=%0d got=%b exp=%b", t, err_illegal, ill_e); end
      checks++; if (req_ready !== rr_e) begin errors++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, req_ready, rr_e); end
      if (rr_e != '0) begin
        gi = pk;
        byt = dat[gi];
        acc = t;
        legal = (byt[1:0] != 2'b00);
        d = $urandom_range(1, T + 8);
        s = legal ? ((d <= T) ? d : T) : 0;
        idle_at = t + s + G + 1;
        ptr = (gi + 1) % NR;
        v[gi] = 1'b0;
      end
    end
    tick();
    req_valid = '0;
    uart_tx_ready = 1'b0;
    drain("rnd_drain");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    uart_tx_ready = 1'b0;
    test_reset();
    test_single_send();
    test_round_robin();
    test_illegal();
    test_timeout();
    test_race();
    test_reset_mid_send();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
